// File: rtl/arbiter5_merge_if.sv
// Handshake bundle for the two-input packet merge: two request channels,
// the merged flit stream and the per-packet winner token stream.
interface arbiter5_merge_if #(
    parameter int unsigned W = 9
);
    logic [W-1:0] In0_data;
    logic         In0_valid;
    logic         In0_ready;
    logic [W-1:0] In1_data;
    logic         In1_valid;
    logic         In1_ready;
    logic [W-1:0] Out_data;
    logic         Out_valid;
    logic         Out_ready;
    logic         S_data;
    logic         S_valid;
    logic         S_ready;

    // Requesters and downstream consumers
    modport master (
        output In0_data, In0_valid, In1_data, In1_valid, Out_ready, S_ready,
        input  In0_ready, In1_ready, Out_data, Out_valid, S_data, S_valid
    );

    // Arbiter side
    modport slave (
        input  In0_data, In0_valid, In1_data, In1_valid, Out_ready, S_ready,
        output In0_ready, In1_ready, Out_data, Out_valid, S_data, S_valid
    );
endinterface

// File: rtl/arbiter5_merge.sv
// Two-input packet-level round-robin merge. A head flit wins the output,
// emits a winner token on S, and locks the output until its tail flit.
module arbiter5_merge #(
    parameter int unsigned W = 9
) (
    input  logic              CLK,
    input  logic              _RESET,
    arbiter5_merge_if.slave   bus
);
    localparam int unsigned TAIL = W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         s_data_q, s_data_d;
    logic         s_valid_q, s_valid_d;

    logic         out_free_c;
    logic         s_free_c;
    logic         winner_c;
    logic [W-1:0] win_data_c;
    logic         in0_ready_c;
    logic         in1_ready_c;

    assign out_free_c = !out_valid_q || bus.Out_ready;
    assign s_free_c   = !s_valid_q || bus.S_ready;
    // On a tie the requester that did not win last time goes next
    assign winner_c   = (bus.In0_valid && bus.In1_valid) ? ~last_grant_q : bus.In1_valid;
    assign win_data_c = winner_c ? bus.In1_data : bus.In0_data;

    // Next-state, register loads and combinational readies
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !bus.Out_ready;
        s_data_d     = s_data_q;
        s_valid_d    = s_valid_q && !bus.S_ready;
        in0_ready_c  = 1'b0;
        in1_ready_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if ((bus.In0_valid || bus.In1_valid) && out_free_c && s_free_c) begin
                    in0_ready_c  = !winner_c;
                    in1_ready_c  = winner_c;
                    out_data_d   = win_data_c;
                    out_valid_d  = 1'b1;
                    s_data_d     = winner_c;
                    s_valid_d    = 1'b1;
                    last_grant_d = winner_c;
                    if (!win_data_c[TAIL]) begin
                        state_d = winner_c ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                in0_ready_c = out_free_c;
                if (bus.In0_valid && out_free_c) begin
                    out_data_d  = bus.In0_data;
                    out_valid_d = 1'b1;
                    if (bus.In0_data[TAIL]) begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK1: begin
                in1_ready_c = out_free_c;
                if (bus.In1_valid && out_free_c) begin
                    out_data_d  = bus.In1_data;
                    out_valid_d = 1'b1;
                    if (bus.In1_data[TAIL]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset favours In0 on the first tie
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            s_data_q     <= 1'b0;
            s_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            s_data_q     <= s_data_d;
            s_valid_q    <= s_valid_d;
        end
    end

    // Readies are held low while reset is asserted
    assign bus.In0_ready = in0_ready_c && _RESET;
    assign bus.In1_ready = in1_ready_c && _RESET;
    assign bus.Out_data  = out_data_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.S_data    = s_data_q;
    assign bus.S_valid   = s_valid_q;
endmodule

// File: tb/tb_arbiter5_merge.sv
// Directed bench for arbiter5_merge: arbitration, packet locking,
// back-pressure on both output streams, async reset and fairness.
module tb_arbiter5_merge;
    localparam int unsigned W = 9;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    arbiter5_merge_if #(.W(W)) bus ();

    arbiter5_merge #(.W(W)) dut (
        .CLK    (clk),
        ._RESET (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.In0_data  = '0;
        bus.In0_valid = 1'b0;
        bus.In1_data  = '0;
        bus.In1_valid = 1'b0;
        bus.Out_ready = 1'b1;
        bus.S_ready   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.In0_data  = 9'h100;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1AB;
        bus.In1_valid = 1'b1;
        bus.Out_ready = 1'b1;
        bus.S_ready   = 1'b1;
        tick();
        checks++; if (bus.Out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.Out_valid); end
        checks++; if (bus.S_valid !== 1'b0) begin failures++; $display("FAIL rst_s_valid got=%b exp=0", bus.S_valid); end
        checks++; if (bus.Out_data !== 9'h000) begin failures++; $display("FAIL rst_out_data got=%h exp=000", bus.Out_data); end
        checks++; if (bus.S_data !== 1'b0) begin failures++; $display("FAIL rst_s_data got=%b exp=0", bus.S_data); end
        checks++; if (bus.In0_ready !== 1'b0) begin failures++; $display("FAIL rst_in0_ready got=%b exp=0", bus.In0_ready); end
        checks++; if (bus.In1_ready !== 1'b0) begin failures++; $display("FAIL rst_in1_ready got=%b exp=0", bus.In1_ready); end
        tick();
        checks++; if (bus.Out_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_out_valid got=%b exp=0", bus.Out_valid); end
    endtask

    task automatic test_alternate();
        logic [W-1:0] exp_d;
        logic         exp_s;
        do_reset();
        bus.In0_data  = 9'h100;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1AB;
        bus.In1_valid = 1'b1;
        #1;
        checks++; if (bus.In0_ready !== 1'b1 || bus.In1_ready !== 1'b0) begin failures++; $display("FAIL alt_first_tie got=%b%b exp=10", bus.In0_ready, bus.In1_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_s = 1'(i % 2);
            exp_d = exp_s ? 9'h1AB : 9'h100;
            checks++; if (bus.Out_valid !== 1'b1 || bus.Out_data !== exp_d) begin failures++; $display("FAIL alt_out[%0d] got=%b/%h exp=1/%h", i, bus.Out_valid, bus.Out_data, exp_d); end
            checks++; if (bus.S_valid !== 1'b1 || bus.S_data !== exp_s) begin failures++; $display("FAIL alt_s[%0d] got=%b/%b exp=1/%b", i, bus.S_valid, bus.S_data, exp_s); end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        bus.In0_data  = 9'h011;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1FF;
        bus.In1_valid = 1'b1;
        tick();
        checks++; if (bus.Out_data !== 9'h011 || bus.S_valid !== 1'b1 || bus.S_data !== 1'b0) begin failures++; $display("FAIL pkt_head got=%h s=%b/%b exp=011 s=1/0", bus.Out_data, bus.S_valid, bus.S_data); end
        checks++; if (bus.In1_ready !== 1'b0 || bus.In0_ready !== 1'b1) begin failures++; $display("FAIL pkt_lock_ready got=%b%b exp=10", bus.In0_ready, bus.In1_ready); end
        bus.In0_data = 9'h022;
        tick();
        checks++; if (bus.Out_valid !== 1'b1 || bus.Out_data !== 9'h022 || bus.S_valid !== 1'b0) begin failures++; $display("FAIL pkt_body got=%b/%h s=%b exp=1/022 s=0", bus.Out_valid, bus.Out_data, bus.S_valid); end
        bus.In0_data = 9'h133;
        tick();
        checks++; if (bus.Out_valid !== 1'b1 || bus.Out_data !== 9'h133 || bus.S_valid !== 1'b0) begin failures++; $display("FAIL pkt_tail got=%b/%h s=%b exp=1/133 s=0", bus.Out_valid, bus.Out_data, bus.S_valid); end
        bus.In0_valid = 1'b0;
        #1;
        checks++; if (bus.In1_ready !== 1'b1) begin failures++; $display("FAIL pkt_release got=%b exp=1", bus.In1_ready); end
        tick();
        checks++; if (bus.Out_data !== 9'h1FF || bus.S_valid !== 1'b1 || bus.S_data !== 1'b1) begin failures++; $display("FAIL pkt_next got=%h s=%b/%b exp=1ff s=1/1", bus.Out_data, bus.S_valid, bus.S_data); end
        bus.In1_valid = 1'b0;
        tick();
        checks++; if (bus.Out_valid !== 1'b0 || bus.S_valid !== 1'b0) begin failures++; $display("FAIL pkt_drain got=%b%b exp=00", bus.Out_valid, bus.S_valid); end
    endtask

    task automatic test_out_backpressure();
        do_reset();
        bus.In0_data  = 9'h011;
        bus.In0_valid = 1'b1;
        tick();
        bus.Out_ready = 1'b0;
        bus.In0_data  = 9'h022;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.Out_valid !== 1'b1 || bus.Out_data !== 9'h011) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/011", k, bus.Out_valid, bus.Out_data); end
            checks++; if (bus.In0_ready !== 1'b0 || bus.S_data !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b s=%b exp=0 s=0", k, bus.In0_ready, bus.S_data); end
            tick();
        end
        bus.Out_ready = 1'b1;
        #1;
        checks++; if (bus.In0_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_ready got=%b exp=1", bus.In0_ready); end
        tick();
        checks++; if (bus.Out_valid !== 1'b1 || bus.Out_data !== 9'h022) begin failures++; $display("FAIL bp_body got=%b/%h exp=1/022", bus.Out_valid, bus.Out_data); end
        bus.In0_data = 9'h133;
        tick();
        checks++; if (bus.Out_data !== 9'h133) begin failures++; $display("FAIL bp_tail got=%h exp=133", bus.Out_data); end
        bus.In0_valid = 1'b0;
        tick();
        checks++; if (bus.Out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.Out_valid); end
    endtask

    task automatic test_s_backpressure();
        do_reset();
        bus.S_ready   = 1'b0;
        bus.In0_data  = 9'h011;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1FF;
        bus.In1_valid = 1'b1;
        tick();
        checks++; if (bus.Out_data !== 9'h011 || bus.S_valid !== 1'b1 || bus.S_data !== 1'b0) begin failures++; $display("FAIL sbp_head got=%h s=%b/%b exp=011 s=1/0", bus.Out_data, bus.S_valid, bus.S_data); end
        bus.In0_data = 9'h133;
        #1;
        checks++; if (bus.In0_ready !== 1'b1 || bus.In1_ready !== 1'b0) begin failures++; $display("FAIL sbp_body_ready got=%b%b exp=10", bus.In0_ready, bus.In1_ready); end
        tick();
        checks++; if (bus.Out_data !== 9'h133 || bus.S_valid !== 1'b1) begin failures++; $display("FAIL sbp_tail got=%h s=%b exp=133 s=1", bus.Out_data, bus.S_valid); end
        bus.In0_valid = 1'b0;
        #1;
        checks++; if (bus.In1_ready !== 1'b0) begin failures++; $display("FAIL sbp_head_blocked got=%b exp=0", bus.In1_ready); end
        tick();
        checks++; if (bus.Out_valid !== 1'b0 || bus.S_valid !== 1'b1 || bus.In1_ready !== 1'b0) begin failures++; $display("FAIL sbp_wait got=%b%b%b exp=010", bus.Out_valid, bus.S_valid, bus.In1_ready); end
        bus.S_ready = 1'b1;
        #1;
        checks++; if (bus.In1_ready !== 1'b1) begin failures++; $display("FAIL sbp_unblock got=%b exp=1", bus.In1_ready); end
        tick();
        checks++; if (bus.Out_data !== 9'h1FF || bus.S_valid !== 1'b1 || bus.S_data !== 1'b1) begin failures++; $display("FAIL sbp_next got=%h s=%b/%b exp=1ff s=1/1", bus.Out_data, bus.S_valid, bus.S_data); end
        bus.In1_valid = 1'b0;
        tick();
        checks++; if (bus.S_valid !== 1'b0) begin failures++; $display("FAIL sbp_drain got=%b exp=0", bus.S_valid); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.In1_data  = 9'h0AA;
        bus.In1_valid = 1'b1;
        tick();
        checks++; if (bus.Out_data !== 9'h0AA || bus.S_data !== 1'b1) begin failures++; $display("FAIL rmp_head got=%h s=%b exp=0aa s=1", bus.Out_data, bus.S_data); end
        bus.Out_ready = 1'b0;
        bus.In1_data  = 9'h0BB;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.Out_valid !== 1'b0 || bus.S_valid !== 1'b0) begin failures++; $display("FAIL rmp_async got=%b%b exp=00", bus.Out_valid, bus.S_valid); end
        checks++; if (bus.Out_data !== 9'h000 || bus.In1_ready !== 1'b0) begin failures++; $display("FAIL rmp_clear got=%h r=%b exp=000 r=0", bus.Out_data, bus.In1_ready); end
        tick();
        rst_n         = 1'b1;
        bus.In0_data  = 9'h100;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1AB;
        bus.In1_valid = 1'b1;
        bus.Out_ready = 1'b1;
        #1;
        checks++; if (bus.In0_ready !== 1'b1 || bus.In1_ready !== 1'b0) begin failures++; $display("FAIL rmp_tie got=%b%b exp=10", bus.In0_ready, bus.In1_ready); end
        tick();
        checks++; if (bus.Out_data !== 9'h100 || bus.S_data !== 1'b0 || bus.S_valid !== 1'b1) begin failures++; $display("FAIL rmp_grant got=%h s=%b/%b exp=100 s=1/0", bus.Out_data, bus.S_valid, bus.S_data); end
        bus.In0_valid = 1'b0;
        bus.In1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int   cnt0;
        int   cnt1;
        int   repeats;
        int   valid_cnt;
        logic prev_s;
        cnt0      = 0;
        cnt1      = 0;
        repeats   = 0;
        valid_cnt = 0;
        prev_s    = 1'b1;
        do_reset();
        bus.In0_data  = 9'h100;
        bus.In0_valid = 1'b1;
        bus.In1_data  = 9'h1AB;
        bus.In1_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.Out_valid === 1'b1) begin
                valid_cnt++;
                if (bus.Out_data === 9'h100) cnt0++;
                if (bus.Out_data === 9'h1AB) cnt1++;
            end
            if (bus.S_valid === 1'b1) begin
                if (i > 0 && bus.S_data === prev_s) repeats++;
                prev_s = bus.S_data;
            end
        end
        checks++; if (cnt0 !== 50) begin failures++; $display("FAIL b2b_count0 got=%0d exp=50", cnt0); end
        checks++; if (cnt1 !== 50) begin failures++; $display("FAIL b2b_count1 got=%0d exp=50", cnt1); end
        checks++; if (repeats !== 0) begin failures++; $display("FAIL b2b_repeat_grants got=%0d exp=0", repeats); end
        checks++; if (valid_cnt !== 100) begin failures++; $display("FAIL b2b_throughput got=%0d exp=100", valid_cnt); end
        bus.In0_valid = 1'b0;
        bus.In1_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.In0_data  = '0;
        bus.In0_valid = 1'b0;
        bus.In1_data  = '0;
        bus.In1_valid = 1'b0;
        bus.Out_ready = 1'b0;
        bus.S_ready   = 1'b0;
        #2;
        test_reset();
        test_alternate();
        test_packet_lock();
        test_out_backpressure();
        test_s_backpressure();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arbiter5_merge.md
ARBITER5_MERGE -- requirements
Module: arbiter5_merge

Interface
REQ-001 Parameter: W, default 9, flit width in bits; bit W-1 is the tail flag, bits W-2:0 payload.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 _RESET  input  1  asynchronous active-low reset.
REQ-004 In0_data  input  W  flit from requester 0.
REQ-005 In0_valid  input  1  In0_data valid.
REQ-006 In0_ready  output  1  arbiter accepts In0 flit this cycle.
REQ-007 In1_data / In1_valid / In1_ready  as REQ-004..006, requester 1.
REQ-008 Out_data  output  W  merged flit stream (registered).
REQ-009 Out_valid  output  1  Out_data valid.
REQ-010 Out_ready  input  1  downstream accepts Out flit.
REQ-011 S_data  output  1  winning requester index, one token per packet (registered).
REQ-012 S_valid  output  1  S_data valid.
REQ-013 S_ready  input  1  downstream accepts S token.

Function
REQ-014 Transfer on any channel occurs in a cycle where valid and ready are both 1 at the rising edge.
REQ-015 State machine states: IDLE, LOCK0, LOCK1; LOCKn means a packet from In n is in progress.
REQ-016 Out register free = !Out_valid || Out_ready; S register free = !S_valid || S_ready.
REQ-017 IDLE: winner = only valid requester; if both valid, the requester != last_grant wins.
REQ-018 IDLE: In_winner_ready = Out register free && S register free; loser ready = 0.
REQ-019 IDLE head accept: Out register loads flit, S register loads winner index, both valids set next cycle.
REQ-020 IDLE head with tail=0 -> LOCKwinner; head with tail=1 -> stays IDLE; last_grant <= winner in both cases.
REQ-021 LOCKn: Inn_ready = Out register free; other input ready = 0; no S token produced.
REQ-022 LOCKn: accepted flit with tail=1 -> IDLE; tail=0 -> stay LOCKn.
REQ-023 Latency: accepted flit appears on Out_data exactly 1 cycle later; full throughput of one flit per cycle when Out_ready held 1.
REQ-024 Out_data/Out_valid and S_data/S_valid hold stable while valid=1 and ready=0.
REQ-025 S token and head flit are produced in the same cycle; each drains independently.
REQ-026 Ready outputs are combinational from state, valids, and Out_ready/S_ready; never from In*_data except via state.
REQ-027 Packets never interleave on Out: flits between head and tail come only from the locked requester.
REQ-028 Requester dropping valid mid-packet leaves state in LOCKn indefinitely (no timeout).

Reset
REQ-029 While _RESET=0: state IDLE, last_grant=1, Out_valid=0, S_valid=0, Out_data=0, S_data=0.
REQ-030 While _RESET=0: In0_ready=0 and In1_ready=0.
REQ-031 Reset asserted mid-packet discards the packet and any held Out/S contents; first post-reset grant favors In0 on tie.

Verification
REQ-032 Reset, both valid, single-flit heads In0=0x100 In1=0x1AB, Out_ready=S_ready=1 -> Out 0x100 S=0, then Out 0x1AB S=1, alternating thereafter.
REQ-033 In0 sends 3-flit packet 0x011,0x022,0x133 while In1 valid with 0x1FF -> Out 0x011,0x022,0x133 consecutive, then 0x1FF; S tokens 0 then 1 only.
REQ-034 Out_ready=0 for 4 cycles after head accepted -> Out_data/S_data stable, In ready=0, no flit lost; resumes on Out_ready=1.
REQ-035 S_ready=0, S token pending, new head waiting -> head not accepted until S drains; body flits of locked packet unaffected.
REQ-036 _RESET pulsed low during LOCK1 -> Out_valid=S_valid=0 immediately (asynchronous), state IDLE, next tie grants In0.
REQ-037 Continuous single-flit traffic on both inputs for 100 cycles -> 50 flits each, no two consecutive grants to same requester.
